carregador_instrucoes: RTL and testbench
========================================

# carregador_instrucoes

Program loader for the single-cycle RISC-V core. It is the writer side of the instruction-memory interface the core only reads. It accepts a byte stream over a valid/ready handshake, packs each group of four bytes little-endian into a 32-bit instruction, and writes the words to consecutive instruction-memory addresses. The core is held in reset until the whole program is stored.

## Interface

Parameters:
- PALAVRAS, default 64: instruction-memory depth in 32-bit words; maximum program length.
- LARG_END, default 6: width of the word index; must satisfy 2^LARG_END >= PALAVRAS.

Ports:
- clock, in, 1: the single clock; all logic is on the rising edge.
- reset, in, 1: asynchronous, active-low; clears every register.
- iniciar, in, 1: pulse that starts a load session; sampled in OCIOSO, FIM and ERRO.
- quant_palavras, in, LARG_END+1: number of words to load; sampled in the cycle iniciar is taken.
- byte_valido, in, 1: the source presents a byte.
- byte_dado, in, 8: the byte value.
- byte_pronto, out, 1: the loader accepts a byte this cycle.
- mem_escrita, out, 1: instruction-memory write strobe, one cycle per word.
- mem_endereco, out, 32: byte address of the word being written; equals word index × 4.
- mem_dado, out, 32: the assembled instruction.
- segura_cpu, out, 1: 1 holds the core in reset.
- concluido, out, 1: the load completed successfully.
- erro, out, 1: the requested word count was invalid.
- soma_verif, out, 8: sum, modulo 256, of all bytes accepted in the current session.

## Operation

- A handshake occurs on a rising edge where byte_valido=1 and byte_pronto=1. Only handshakes consume bytes.
- States:
  - OCIOSO:
    - byte_pronto=0, segura_cpu=1.
    - iniciar=1 with 1 <= quant_palavras <= PALAVRAS: go to RECEBE. Clear the index, the byte counter and soma_verif, and latch quant_palavras.
    - iniciar=1 with any other quant_palavras: go to ERRO.
  - RECEBE:
    - byte_pronto=1.
    - On each handshake, place byte_dado in lane cont_byte of the assembly register. Lane 0 is bits 7:0 and lane 3 is bits 31:24.
    - On each handshake, add byte_dado to soma_verif (8-bit, wraps) and increment cont_byte (2-bit).
    - The 4th handshake moves to GRAVA.
  - GRAVA, exactly one cycle:
    - mem_escrita=1, byte_pronto=0.
    - mem_endereco = {index, 2'b00} zero-extended to 32 bits.
    - mem_dado = the assembled word.
    - The index increments. If the new index equals the latched count, go to FIM; otherwise go to RECEBE.
  - FIM:
    - concluido=1, segura_cpu=0, byte_pronto=0.
    - iniciar re-evaluates exactly as in OCIOSO. When it is taken, concluido and segura_cpu drop on the next edge.
  - ERRO:
    - erro=1, segura_cpu=1, byte_pronto=0.
    - iniciar re-evaluates exactly as in OCIOSO; erro clears when it is accepted.
- iniciar is ignored in RECEBE and GRAVA.
- Bytes offered outside RECEBE are not consumed and are not counted.
- mem_endereco and mem_dado are registered. They hold their last value outside GRAVA; the memory must only honour them when mem_escrita=1.
- Addresses never wrap within a session, because the count is at most PALAVRAS.

## Timing

Reset values of all outputs:
- byte_pronto=0, mem_escrita=0, mem_endereco=0, mem_dado=0.
- segura_cpu=1, concluido=0, erro=0, soma_verif=0.
- State: OCIOSO.

Cycle-level behaviour:
- If iniciar is taken at edge k, then state=RECEBE and byte_pronto=1 during cycle k+1.
- With byte_valido held at 1, the four handshakes fall on edges k+1 to k+4 and mem_escrita=1 in cycle k+5.
- Peak throughput is 5 cycles per word. An N-word load asserts concluido 5N+1 cycles after iniciar is taken, at the earliest.
- Idle cycles on byte_valido stretch RECEBE without losing or duplicating lanes.
- Reset asserted mid-session aborts immediately:
  - No further writes occur and the partial word is discarded.
  - Outputs take their reset values asynchronously.

## Test plan

- Reset: assert reset=0 at random points -> all outputs at reset values within the same cycle; OCIOSO after release.
- Single word: quant=1, then bytes 0x13, 0x00, 0x50, 0x00 back-to-back -> exactly one write with addr 0x0, data 0x00500013; soma_verif=0x63; concluido=1 and segura_cpu=0 from the following cycle.
- Three words with random byte_valido gaps -> writes to 0x0, 0x4 and 0x8 with the correct little-endian packing, each exactly once; byte_pronto=0 in every GRAVA cycle.
- Invalid counts: quant=0, then quant=65 (PALAVRAS=64) -> erro=1, no writes, segura_cpu=1; a following iniciar with quant=2 clears erro and loads normally.
- Abort: reset after 2 handshakes of word 0 -> no write; a subsequent full 1-word load writes only the new data.
- Restart and ignore: iniciar pulsed during RECEBE -> no effect; iniciar in FIM with quant=1 -> segura_cpu=1 and concluido=0 next cycle, soma_verif restarts from 0.

Source files
------------

// File: rtl/carregador_instrucoes.sv
// Program loader: packs a byte stream little-endian into 32-bit words and writes them to
// consecutive instruction-memory addresses, holding the core in reset until the load completes.
module carregador_instrucoes #(
  parameter int unsigned PALAVRAS = 64,
  parameter int unsigned LARG_END = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [LARG_END:0]   quant_palavras,
  input  logic                byte_valido,
  input  logic [7:0]          byte_dado,
  output logic                byte_pronto,
  output logic                mem_escrita,
  output logic [31:0]         mem_endereco,
  output logic [31:0]         mem_dado,
  output logic                segura_cpu,
  output logic                concluido,
  output logic                erro,
  output logic [7:0]          soma_verif
);

  typedef enum logic [2:0] {StOcioso, StRecebe, StGrava, StFim, StErro} estado_e;

  estado_e             estado_q, estado_d;
  logic [LARG_END:0]   indice_q, indice_d;
  logic [LARG_END:0]   quant_q, quant_d;
  logic [1:0]          cont_q, cont_d;
  logic [31:0]         palavra_q, palavra_d;
  logic [31:0]         palavra_nova;
  logic                pronto_q, pronto_d;
  logic                escrita_q, escrita_d;
  logic [31:0]         endereco_q, endereco_d;
  logic [31:0]         dado_q, dado_d;
  logic                segura_q, segura_d;
  logic                concluido_q, concluido_d;
  logic                erro_q, erro_d;
  logic [7:0]          soma_q, soma_d;
  logic                handshake;
  logic                quant_ok;

  // pronto_q is high exactly while in StRecebe, so it alone qualifies the handshake.
  assign handshake = byte_valido & pronto_q;
  assign quant_ok  = (quant_palavras != '0) && (32'(quant_palavras) <= PALAVRAS);

  always_comb begin
    palavra_nova = palavra_q;
    palavra_nova[{cont_q, 3'b000} +: 8] = byte_dado;

    estado_d   = estado_q;
    indice_d   = indice_q;
    quant_d    = quant_q;
    cont_d     = cont_q;
    palavra_d  = palavra_q;
    escrita_d  = 1'b0;
    endereco_d = endereco_q;
    dado_d     = dado_q;
    soma_d     = soma_q;

    unique case (estado_q)
      StOcioso, StFim, StErro: begin
        if (iniciar) begin
          if (quant_ok) begin
            estado_d = StRecebe;
            indice_d = '0;
            cont_d   = '0;
            soma_d   = '0;
            quant_d  = quant_palavras;
          end else begin
            estado_d = StErro;
          end
        end
      end
      StRecebe: begin
        if (handshake) begin
          palavra_d = palavra_nova;
          soma_d    = soma_q + byte_dado;
          cont_d    = cont_q + 2'd1;
          if (cont_q == 2'd3) begin
            estado_d   = StGrava;
            escrita_d  = 1'b1;
            endereco_d = 32'({indice_q, 2'b00});
            dado_d     = palavra_nova;
          end
        end
      end
      StGrava: begin
        indice_d = indice_q + 1'b1;
        estado_d = (indice_q + 1'b1 == quant_q) ? StFim : StRecebe;
      end
      default: estado_d = StOcioso;
    endcase

    pronto_d    = (estado_d == StRecebe);
    concluido_d = (estado_d == StFim);
    erro_d      = (estado_d == StErro);
    segura_d    = (estado_d != StFim);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= StOcioso;
      indice_q    <= '0;
      quant_q     <= '0;
      cont_q      <= '0;
      palavra_q   <= '0;
      pronto_q    <= 1'b0;
      escrita_q   <= 1'b0;
      endereco_q  <= '0;
      dado_q      <= '0;
      segura_q    <= 1'b1;
      concluido_q <= 1'b0;
      erro_q      <= 1'b0;
      soma_q      <= '0;
    end else begin
      estado_q    <= estado_d;
      indice_q    <= indice_d;
      quant_q     <= quant_d;
      cont_q      <= cont_d;
      palavra_q   <= palavra_d;
      pronto_q    <= pronto_d;
      escrita_q   <= escrita_d;
      endereco_q  <= endereco_d;
      dado_q      <= dado_d;
      segura_q    <= segura_d;
      concluido_q <= concluido_d;
      erro_q      <= erro_d;
      soma_q      <= soma_d;
    end
  end

  assign byte_pronto  = pronto_q;
  assign mem_escrita  = escrita_q;
  assign mem_endereco = endereco_q;
  assign mem_dado     = dado_q;
  assign segura_cpu   = segura_q;
  assign concluido    = concluido_q;
  assign erro         = erro_q;
  assign soma_verif   = soma_q;

endmodule

// File: tb/tb_carregador_instrucoes.sv
// Scoreboard bench for carregador_instrucoes: expected writes are queued by the stimulus and
// popped by a monitor on every mem_escrita cycle.
module tb_carregador_instrucoes;

  logic        clock;
  logic        reset;
  logic        iniciar;
  logic [6:0]  quant_palavras;
  logic        byte_valido;
  logic [7:0]  byte_dado;
  logic        byte_pronto;
  logic        mem_escrita;
  logic [31:0] mem_endereco;
  logic [31:0] mem_dado;
  logic        segura_cpu;
  logic        concluido;
  logic        erro;
  logic [7:0]  soma_verif;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] prog [0:3];

  carregador_instrucoes #(.PALAVRAS(64), .LARG_END(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .quant_palavras (quant_palavras),
    .byte_valido    (byte_valido),
    .byte_dado      (byte_dado),
    .byte_pronto    (byte_pronto),
    .mem_escrita    (mem_escrita),
    .mem_endereco   (mem_endereco),
    .mem_dado       (mem_dado),
    .segura_cpu     (segura_cpu),
    .concluido      (concluido),
    .erro           (erro),
    .soma_verif     (soma_verif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clock) begin
    if (mem_escrita === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", mem_endereco,
                 mem_dado);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_endereco, e[63:32]);
        chk("wr_data", mem_dado, e[31:0]);
        chk("pronto_in_grava", {31'b0, byte_pronto}, 32'd0);
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_pronto", {31'b0, byte_pronto}, 32'd0);
    chk("rst_escrita", {31'b0, mem_escrita}, 32'd0);
    chk("rst_endereco", mem_endereco, 32'd0);
    chk("rst_dado", mem_dado, 32'd0);
    chk("rst_segura", {31'b0, segura_cpu}, 32'd1);
    chk("rst_concluido", {31'b0, concluido}, 32'd0);
    chk("rst_erro", {31'b0, erro}, 32'd0);
    chk("rst_soma", {24'b0, soma_verif}, 32'd0);
  endtask

  // Called at a negedge; asserts reset mid-cycle and checks outputs before any clock edge.
  task automatic reset_pulse();
    iniciar = 1'b0;
    byte_valido = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs();
  endtask

  task automatic start(input int q);
    iniciar = 1'b1;
    quant_palavras = 7'(q);
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      byte_valido = 1'b0;
      @(negedge clock);
    end
    byte_valido = 1'b1;
    byte_dado = b;
    n = 0;
    while (byte_pronto !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL pronto_timeout: byte_pronto stayed low");
    end
    @(negedge clock);
    byte_valido = 1'b0;
  endtask

  // Feeds prog[0..n-1]; returns the expected checksum. poke pulses iniciar mid-word.
  task automatic feed(input int n, input bit gaps, input bit poke, output logic [7:0] s);
    logic [7:0] b;
    s = 8'd0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({32'(i * 4), prog[i]});
      for (int k = 0; k < 4; k++) begin
        b = prog[i][8 * k +: 8];
        s = s + b;
        if (poke && i == 0 && k == 2) start(1);
        send_byte(b, gaps ? int'($urandom_range(0, 2)) : 0);
      end
    end
  endtask

  task automatic wait_done(input string name, input logic [7:0] s);
    int n;
    n = 0;
    while (concluido !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_concluido"}, {31'b0, concluido}, 32'd1);
    chk({name, "_segura"}, {31'b0, segura_cpu}, 32'd0);
    chk({name, "_soma"}, {24'b0, soma_verif}, {24'b0, s});
    chk({name, "_erro"}, {31'b0, erro}, 32'd0);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] s;
    reset = 1'b1;
    iniciar = 1'b0;
    quant_palavras = '0;
    byte_valido = 1'b0;
    byte_dado = '0;
    prog[0] = 32'h00500013;
    prog[1] = 32'hDEADBEEF;
    prog[2] = 32'h12345678;
    prog[3] = 32'hA5C3017F;
    @(negedge clock);
    reset_pulse();

    // Single word, back-to-back, with exact cycle timing.
    start(1);
    chk("sw_pronto_k1", {31'b0, byte_pronto}, 32'd1);
    chk("sw_segura_k1", {31'b0, segura_cpu}, 32'd1);
    exp_q.push_back({32'h0, 32'h00500013});
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h50, 0);
    send_byte(8'h00, 0);
    chk("sw_escrita_k5", {31'b0, mem_escrita}, 32'd1);
    chk("sw_concluido_k5", {31'b0, concluido}, 32'd0);
    @(negedge clock);
    chk("sw_concluido_k6", {31'b0, concluido}, 32'd1);
    chk("sw_segura_k6", {31'b0, segura_cpu}, 32'd0);
    chk("sw_soma", {24'b0, soma_verif}, 32'h63);
    chk("sw_pronto_k6", {31'b0, byte_pronto}, 32'd0);

    // Restart from FIM.
    start(1);
    chk("rs_segura", {31'b0, segura_cpu}, 32'd1);
    chk("rs_concluido", {31'b0, concluido}, 32'd0);
    chk("rs_soma", {24'b0, soma_verif}, 32'd0);
    feed(1, 1'b0, 1'b0, s);
    wait_done("rs", s);

    // Three words with random gaps.
    start(3);
    feed(3, 1'b1, 1'b0, s);
    wait_done("w3", s);

    // Invalid counts, then a valid load clears erro.
    start(0);
    chk("inv0_erro", {31'b0, erro}, 32'd1);
    chk("inv0_segura", {31'b0, segura_cpu}, 32'd1);
    chk("inv0_concluido", {31'b0, concluido}, 32'd0);
    byte_valido = 1'b1;
    @(negedge clock);
    chk("inv0_pronto", {31'b0, byte_pronto}, 32'd0);
    byte_valido = 1'b0;
    start(65);
    chk("inv65_erro", {31'b0, erro}, 32'd1);
    chk("inv65_segura", {31'b0, segura_cpu}, 32'd1);
    start(2);
    chk("inv_clear_erro", {31'b0, erro}, 32'd0);
    feed(2, 1'b0, 1'b0, s);
    wait_done("inv_load", s);

    // Maximum valid count boundary is accepted (checked then aborted).
    start(64);
    chk("max_erro", {31'b0, erro}, 32'd0);
    chk("max_pronto", {31'b0, byte_pronto}, 32'd1);

    // Abort after two handshakes: partial word never written.
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset_pulse();
    start(1);
    feed(1, 1'b0, 1'b0, s);
    wait_done("abort", s);

    // iniciar ignored during RECEBE.
    start(2);
    feed(2, 1'b1, 1'b1, s);
    wait_done("ignore", s);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
